// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one external combinational ALU between two requesters.
//
// Operation:
// - Grants are issued with round-robin priority.
// - The winner's operands are latched into registers that drive the ALU.
// - One cycle later the ALU outputs are captured and returned, tagged with
//   the id of the requester that owns the result.
// - Illegal opcodes are never issued to the ALU. They return a zero result
//   with res_err set.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req0/op0/a0/b0      requester 0 request, opcode and operands
//   gnt0                requester 0 grant (combinational, one-cycle pulse)
//   req1/op1/a1/b1      requester 1 request, opcode and operands
//   gnt1                requester 1 grant (combinational, one-cycle pulse)
//   alu_a/alu_b/alu_op  registered ALU inputs
//   alu_r/alu_c32/alu_z/alu_v  ALU outputs (result and flags)
//   res/res_c32/res_z/res_v    registered result and flags
//   res_id              requester that owns res
//   res_err             illegal opcode was rejected (res is zero)
//   res_valid           one-cycle pulse marking res* valid
//   busy                FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [OP_W-1:0]  op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [OP_W-1:0]  op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_c32,
  input  logic             alu_z,
  input  logic             alu_v,
  output logic [WIDTH-1:0] res,
  output logic             res_c32,
  output logic             res_z,
  output logic             res_v,
  output logic             res_id,
  output logic             res_err,
  output logic             res_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_REJECT = 2'b10
  } state_t;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  // Only these five opcodes reach the ALU; everything else is rejected.
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_c32_q, res_c32_d;
  logic             res_z_q, res_z_d;
  logic             res_v_q, res_v_d;
  logic             res_id_q, res_id_d;
  logic             res_err_q, res_err_d;
  logic             res_valid_q, res_valid_d;

  logic             gnt0_s, gnt1_s;
  logic             sel_id_s;
  logic [OP_W-1:0]  sel_op_s;
  logic [WIDTH-1:0] sel_a_s, sel_b_s;

  // Round-robin grant: on a tie the requester that did not win last time goes
  // first. Grants are held low during reset so nothing is offered mid-reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if ((state_q == ST_IDLE) && !reset) begin
      if (req0 && req1) begin
        if (last_id_q) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (req0) begin
        gnt0_s = 1'b1;
      end else if (req1) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    if (gnt1_s) begin
      sel_id_s = 1'b1;
      sel_op_s = op1;
      sel_a_s  = a1;
      sel_b_s  = b1;
    end else begin
      sel_id_s = 1'b0;
      sel_op_s = op0;
      sel_a_s  = a0;
      sel_b_s  = b0;
    end
  end

  // Next-state and datapath update. last_id doubles as the owner of the
  // in-flight operation, since it is written with the granted id.
  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_d       = res_q;
    res_c32_d   = res_c32_q;
    res_z_d     = res_z_q;
    res_v_d     = res_v_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;
    res_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt0_s || gnt1_s) begin
          last_id_d = sel_id_s;
          if (is_legal(sel_op_s)) begin
            alu_a_d  = sel_a_s;
            alu_b_d  = sel_b_s;
            alu_op_d = sel_op_s;
            state_d  = ST_ISSUE;
          end else begin
            // ALU inputs stay put so a rejected op causes no toggling.
            state_d = ST_REJECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        res_d       = alu_r;
        res_c32_d   = alu_c32;
        res_z_d     = alu_z;
        res_v_d     = alu_v;
        res_id_d    = last_id_q;
        res_err_d   = 1'b0;
        res_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_REJECT: begin
        res_d       = {WIDTH{1'b0}};
        res_c32_d   = 1'b0;
        res_z_d     = 1'b0;
        res_v_d     = 1'b0;
        res_id_d    = last_id_q;
        res_err_d   = 1'b1;
        res_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_id_q   <= 1'b1;
      alu_a_q     <= {WIDTH{1'b0}};
      alu_b_q     <= {WIDTH{1'b0}};
      alu_op_q    <= {OP_W{1'b0}};
      res_q       <= {WIDTH{1'b0}};
      res_c32_q   <= 1'b0;
      res_z_q     <= 1'b0;
      res_v_q     <= 1'b0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_q       <= res_d;
      res_c32_q   <= res_c32_d;
      res_z_q     <= res_z_d;
      res_v_q     <= res_v_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign gnt0      = gnt0_s;
  assign gnt1      = gnt1_s;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res       = res_q;
  assign res_c32   = res_c32_q;
  assign res_z     = res_z_q;
  assign res_v     = res_v_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed test of alu_share_arbiter, with a behavioural ALU attached to the
// alu_* pins.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_c32, alu_z, alu_v;
  logic [31:0] res;
  logic        res_c32, res_z, res_v, res_id, res_err, res_valid;
  logic        busy;

  int vectors;
  int miscompares;

  alu_share_arbiter #(.WIDTH(32), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_c32(alu_c32), .alu_z(alu_z), .alu_v(alu_v),
    .res(res), .res_c32(res_c32), .res_z(res_z), .res_v(res_v),
    .res_id(res_id), .res_err(res_err), .res_valid(res_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: SUB/SLT compute a + ~b + 1, c32 is the raw carry-out.
  logic [32:0] sum;
  logic        is_sub;
  always_comb begin
    is_sub  = (alu_op == 3'b110) || (alu_op == 3'b111);
    sum     = {1'b0, alu_a} + {1'b0, (is_sub ? ~alu_b : alu_b)} + {32'd0, is_sub};
    alu_c32 = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      3'b000: alu_r = alu_a & alu_b;
      3'b001: alu_r = alu_a | alu_b;
      3'b010: begin
        alu_r   = sum[31:0];
        alu_c32 = sum[32];
        alu_v   = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'b110: begin
        alu_r   = sum[31:0];
        alu_c32 = sum[32];
        alu_v   = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
      end
      3'b111: begin
        alu_c32 = sum[32];
        alu_v   = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
        alu_r   = {31'd0, sum[31] ^ alu_v};
      end
      default: alu_r = 32'd0;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the full result bundle in a res_valid cycle.
  task automatic chk_res(input string tag, input logic [31:0] r, input logic c,
                         input logic z, input logic v, input logic id,
                         input logic err);
    chk({tag, ".valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, ".res"},   res, r);
    chk({tag, ".c32"},   {31'd0, res_c32}, {31'd0, c});
    chk({tag, ".z"},     {31'd0, res_z},   {31'd0, z});
    chk({tag, ".v"},     {31'd0, res_v},   {31'd0, v});
    chk({tag, ".id"},    {31'd0, res_id},  {31'd0, id});
    chk({tag, ".err"},   {31'd0, res_err}, {31'd0, err});
  endtask

  // Single request from requester 0: grant now, result two cycles later.
  task automatic run0(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    #1;
    chk({tag, ".gnt0"}, {31'd0, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = 3'b000; op1 = 3'b000;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;

    // Reset state
    tick();
    chk("rst.busy",   {31'd0, busy}, 32'd0);
    chk("rst.gnt",    {30'd0, gnt1, gnt0}, 32'd0);
    chk("rst.valid",  {31'd0, res_valid}, 32'd0);
    chk("rst.alu_a",  alu_a, 32'd0);
    chk("rst.alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst.res",    res, 32'd0);
    chk("rst.flags",  {27'd0, res_c32, res_z, res_v, res_id, res_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Tie with round-robin: requester 0 first after reset
    req0 = 1'b1; op0 = 3'b000; a0 = 32'h0000_F0F0; b0 = 32'h0000_FF00;
    req1 = 1'b1; op1 = 3'b001; a1 = 32'h0000_000F; b1 = 32'h0000_00F0;
    #1;
    chk("tie1.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    chk("tie1.issue.gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("tie1.alu_op", {29'd0, alu_op}, 32'd0);
    chk("tie1.busy", {31'd0, busy}, 32'd1);
    tick();
    chk_res("tie1", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tie2.gnt", {30'd0, gnt1, gnt0}, 32'd2);
    tick();
    chk("tie2.alu_op", {29'd0, alu_op}, 32'd1);
    tick();
    chk_res("tie2", 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("tie3.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_res("tie3", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tie3.nogrant", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk("tie3.pulse", {31'd0, res_valid}, 32'd0);
    chk("tie3.hold", res, 32'h0000_F000);

    // Single request: ADD 5 + 7
    req0 = 1'b1; op0 = 3'b010; a0 = 32'd5; b0 = 32'd7;
    #1;
    chk("add.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    chk("add.idle", {31'd0, busy}, 32'd0);
    tick();
    req0 = 1'b0;
    chk("add.alu_a", alu_a, 32'd5);
    chk("add.alu_b", alu_b, 32'd7);
    chk("add.alu_op", {29'd0, alu_op}, 32'd2);
    chk("add.early", {31'd0, res_valid}, 32'd0);
    tick();
    chk_res("add", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add.busy", {31'd0, busy}, 32'd0);

    // SUB/SLT flags
    run0("sub1", 3'b110, 32'h8000_0000, 32'h7FFF_FFFF);
    chk_res("sub1", 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run0("sub2", 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_res("sub2", 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run0("slt", 3'b111, 32'd3, 32'd8);
    chk("slt.res", res, 32'd1);
    chk("slt.z", {31'd0, res_z}, 32'd0);

    // Illegal opcode from requester 1: ALU inputs untouched
    req1 = 1'b1; op1 = 3'b101; a1 = 32'hDEAD_BEEF; b1 = 32'h1234_5678;
    #1;
    chk("ill.gnt", {30'd0, gnt1, gnt0}, 32'd2);
    tick();
    req1 = 1'b0;
    chk("ill.busy", {31'd0, busy}, 32'd1);
    chk("ill.alu_op", {29'd0, alu_op}, 32'd7);
    chk("ill.alu_a", alu_a, 32'd3);
    chk("ill.alu_b", alu_b, 32'd8);
    tick();
    chk_res("ill", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("ill.alu_op2", {29'd0, alu_op}, 32'd7);
    tick();

    // Reset during ISSUE
    req0 = 1'b1; op0 = 3'b010; a0 = 32'd1; b0 = 32'd1;
    #1;
    chk("mid.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    chk("mid.busy", {31'd0, busy}, 32'd1);
    req0 = 1'b1; req1 = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid.rst.busy", {31'd0, busy}, 32'd0);
    chk("mid.rst.gnt", {30'd0, gnt1, gnt0}, 32'd0);
    chk("mid.rst.alu_a", alu_a, 32'd0);
    chk("mid.rst.res", res, 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid.nv1", {31'd0, res_valid}, 32'd0);
    tick();
    chk("mid.nv2", {31'd0, res_valid}, 32'd0);
    req0 = 1'b1; op0 = 3'b001; a0 = 32'h0000_0100; b0 = 32'h0000_0001;
    req1 = 1'b1; op1 = 3'b000; a1 = 32'd0; b1 = 32'd0;
    #1;
    chk("mid.tie.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_res("mid.tie", 32'h0000_0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back from requester 0
    req0 = 1'b1; op0 = 3'b010; a0 = 32'd10; b0 = 32'd20;
    #1;
    chk("b2b1.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    op0 = 3'b010; a0 = 32'd100; b0 = 32'd200;
    chk("b2b1.gap", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk_res("b2b1", 32'd30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b2.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    op0 = 3'b001; a0 = 32'd7; b0 = 32'd8;
    chk("b2b2.gap", {30'd0, gnt1, gnt0}, 32'd0);
    tick();
    chk_res("b2b2", 32'd300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b3.gnt", {30'd0, gnt1, gnt0}, 32'd1);
    tick();
    req0 = 1'b0;
    tick();
    chk_res("b2b3", 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b3.nogrant", {30'd0, gnt1, gnt0}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU (ops AND/OR/ADD/SUB/SLT; outputs result, carry-out c32, zero Z, overflow V) between two requesters, e.g. the main datapath and a branch/address unit.
- Round-robin arbitration with a req/gnt handshake.
- Latches the winner's operands and drives the ALU from registers.
- Captures the ALU outputs and returns them tagged with the requester id.
- Rejects illegal opcodes without issuing them to the ALU.

Parameters:
- WIDTH, 32, operand/result width.
- OP_W, 3, ALU opcode width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held with a0/b0/op0 stable until gnt0.
- op0  input  OP_W  requester 0 opcode.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- gnt0  output  1  requester 0 grant; one-cycle pulse, operands captured at this edge.
- req1, op1, a1, b1, gnt1  same as the requester 0 ports, for requester 1.
- alu_a  output  WIDTH  registered ALU operand A.
- alu_b  output  WIDTH  registered ALU operand B.
- alu_op  output  OP_W  registered ALU opcode.
- alu_r  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_c32  input  1  ALU carry-out.
- alu_z  input  1  ALU zero flag.
- alu_v  input  1  ALU overflow flag.
- res  output  WIDTH  registered result.
- res_c32  output  1  registered carry-out.
- res_z  output  1  registered zero flag.
- res_v  output  1  registered overflow flag.
- res_id  output  1  requester that owns res.
- res_err  output  1  illegal opcode; res is 0.
- res_valid  output  1  one-cycle pulse marking res/flags/id/err valid.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (async): state=IDLE; last_id=1, so requester 0 wins the first tie.
- Reset: gnt0=gnt1=0; res_valid=0; alu_a/alu_b/res=0; alu_op=000.
- Reset: res_c32/res_z/res_v/res_id/res_err=0; busy=0.
- Legal opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. 011, 100 and 101 are illegal.
- FSM states: IDLE, ISSUE, REJECT.
- IDLE, no request: stay in IDLE.
- IDLE, exactly one req: grant it.
- IDLE, both req: grant the requester != last_id.
- Grant logic: gnt combinational, asserted only in IDLE, at most one gnt high per cycle.
- Grant edge, legal opcode: latch a/b/op into alu_a/alu_b/alu_op; set last_id := granted id; go to ISSUE.
- Grant edge, illegal opcode: alu_* unchanged (ALU inputs do not toggle); set last_id := granted id; go to REJECT.
- ISSUE (one cycle): ALU settles. End-of-cycle edge registers alu_r/c32/z/v into res*, sets res_id, res_err=0, res_valid=1, then returns to IDLE.
- REJECT (one cycle): end-of-cycle edge sets res=0, flags=0, res_err=1, res_id, res_valid=1, then returns to IDLE.
- Latency: gnt in cycle C, res_valid in cycle C+2. Throughput: one op per 2 cycles.
- A new gnt may coincide with res_valid, since the FSM is back in IDLE.
- res_valid is high for exactly one cycle. res* hold their value until the next res_valid. alu_* hold until the next legal grant.
- req dropped before grant: no action; there is no commitment before gnt.
- req held after gnt: treated as a new request in the next IDLE cycle. Requesters deassert req in the cycle after gnt.
- Reset mid-operation (ISSUE/REJECT): in-flight op discarded, no res_valid, all registers take reset values immediately.
- Flags pass through unmodified; the arbiter performs no arithmetic. Widths are fixed at WIDTH/OP_W with no extension.

Test Plan:
- Single request: req0, op=010, a0=5, b0=7 -> gnt0 in cycle C; alu_a=5, alu_b=7, alu_op=010 in C+1; res=12, c32=0, Z=0, V=0, res_id=0, res_valid in C+2.
- Tie with round-robin: req0 and req1 held high continuously, op0=000, op1=001 -> grants alternate gnt0, gnt1, gnt0 (requester 0 first after reset), one grant every 2 cycles, res_id alternates 0, 1, 0.
- SUB/SLT flags:
  - op=110, a=0x80000000, b=0x7FFFFFFF -> res=0x00000001, V=1.
  - op=110, a=b=0xFFFFFFFF -> res=0, Z=1.
  - op=111, a=3, b=8 -> res=1.
- Illegal opcode: req1, op1=101 -> gnt1; alu_op unchanged; res_valid 2 cycles after gnt with res_err=1, res=0, res_id=1.
- Reset mid-operation: assert reset during ISSUE -> busy=0 and gnt=0 immediately; no res_valid afterwards; next tie grants requester 0.
- Back-to-back: req0 only, with new operands presented each grant -> gnt0 every 2nd cycle; each res_valid coincides with the next gnt0; results are in order.
